serial_adder: RTL

//  Parametrised multi-cycle adder: WIDTH-bit a + b + cin computed CHUNK bits per cycle with a registered carry.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_add_chunk.sv | 23 ++
 rtl/serial_adder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Step counter keeps at least one bit so STEPS==1 still elaborates.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_add_chunk.sv
// Combinational CHUNK-bit ripple adder used for one step of the serial adder.
module add_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle a+b+cin adder, CHUNK bits per cycle with a registered carry.
// Define SUB_MODE_EN to add the sub port (a - b via inverted b and forced carry-in).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = steps(WIDTH, CHUNK);
    localparam int CW    = cnt_w(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be at least 2");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] b_eff;
    logic             carry_init;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] a_next, b_next;
    logic             accept, last_step;

`ifdef SUB_MODE_EN
    assign b_eff      = sub ? ~b : b;
    assign carry_init = sub | cin;
`else
    assign b_eff      = b;
    assign carry_init = cin;
`endif

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (s_chunk),
        .cout (c_chunk)
    );

    // New chunk enters the sum from the MSB side; after STEPS shifts the word is complete.
    if (CHUNK == WIDTH) begin : g_one_step
        assign sum_next = s_chunk;
        assign a_next   = '0;
        assign b_next   = '0;
    end else begin : g_multi_step
        assign sum_next = {s_chunk, sum[WIDTH-1:CHUNK]};
        assign a_next   = a_sh >> CHUNK;
        assign b_next   = b_sh >> CHUNK;
    end

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_step = (state_q == RUN) && (count_q == LAST);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (count_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                carry_q <= carry_init;
                count_q <= '0;
            end else if (state_q == RUN) begin
                carry_q <= c_chunk;
                count_q <= count_q + CW'(1);
                sum     <= sum_next;
                if (last_step) begin
                    cout <= c_chunk;
                    ovf  <= (a_msb_q == b_msb_q) && (s_chunk[CHUNK-1] != a_msb_q);
                end
            end
        end
    end

    // Operand shift registers carry only data and are fully reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh    <= a;
            b_sh    <= b_eff;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
        end else if (state_q == RUN) begin
            a_sh <= a_next;
            b_sh <= b_next;
        end
    end

endmodule
